// File: rtl/stopwatch_core.sv
// Stopwatch timing engine: 00.00-99.99 BCD count at 0.01 s with run/stop/clear FSM and
// registered active-low 7-segment outputs. Define STOPWATCH_LAP_EN to add the lap-hold input.
module stopwatch_core #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
`endif
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic       running,
  output logic       at_max
);

  typedef enum logic [1:0] {StIdle, StRun, StStop, StMax} state_e;

  localparam logic [CNT_W-1:0] PrescMax = CNT_W'(TICK_DIV - 1);

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  // Nibbles: [15:12]=d0 tens of seconds ... [3:0]=d3 hundredths.
  logic [15:0]      dig_q, dig_d, dig_inc;
  logic             ss_q, clr_q;
  logic             ss_edge, clr_edge, all_nines, carry;
  logic             seg_freeze;

  assign ss_edge   = start_stop & ~ss_q;
  assign clr_edge  = clear & ~clr_q;
  assign all_nines = (dig_q == 16'h9999);

  // BCD ripple increment starting at the hundredths digit.
  always_comb begin
    dig_inc = dig_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig_q[i*4 +: 4] == 4'd9) begin
          dig_inc[i*4 +: 4] = 4'd0;
        end else begin
          dig_inc[i*4 +: 4] = dig_q[i*4 +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Priority: clear edge, then start/stop edge, then prescaler tick.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dig_d   = dig_q;
    if (clr_edge) begin
      state_d = StIdle;
      presc_d = '0;
      dig_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ss_edge) begin
            state_d = StRun;
            presc_d = '0;
          end
        end
        StRun: begin
          if (ss_edge) begin
            state_d = StStop;
          end else if (presc_q == PrescMax) begin
            presc_d = '0;
            if (all_nines) begin
              state_d = StMax;
            end else begin
              dig_d = dig_inc;
            end
          end else begin
            presc_d = presc_q + CNT_W'(1);
          end
        end
        StStop: begin
          if (ss_edge) begin
            state_d = StRun;
          end
        end
        StMax:   ;
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_q, lap_edge, lap_hold_q, lap_hold_d;

  assign lap_edge = lap & ~lap_q;
  // Hold survives only while staying in RUN; any exit (clear, stop, max) drops it.
  assign lap_hold_d = (state_q == StRun && state_d == StRun) ? (lap_hold_q ^ lap_edge) : 1'b0;
  assign seg_freeze = lap_hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_q      <= 1'b1;
      lap_hold_q <= 1'b0;
    end else begin
      lap_q      <= lap;
      lap_hold_q <= lap_hold_d;
    end
  end
`else
  assign seg_freeze = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      dig_q   <= '0;
      ss_q    <= 1'b1;
      clr_q   <= 1'b1;
      seg0    <= 7'b1000000;
      seg1    <= 7'b1000000;
      seg2    <= 7'b1000000;
      seg3    <= 7'b1000000;
      running <= 1'b0;
      at_max  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dig_q   <= dig_d;
      ss_q    <= start_stop;
      clr_q   <= clear;
      running <= (state_d == StRun);
      at_max  <= (state_d == StMax);
      if (!seg_freeze) begin
        seg0 <= seg_enc(dig_q[15:12]);
        seg1 <= seg_enc(dig_q[11:8]);
        seg2 <= seg_enc(dig_q[7:4]);
        seg3 <= seg_enc(dig_q[3:0]);
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core at TICK_DIV=4; expected outputs go through a scoreboard queue.
module tb_stopwatch_core;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;

  logic       clk = 1'b0;
  logic       rst_n, start_stop, clear;
  logic [6:0] seg0, seg1, seg2, seg3;
  logic       running, at_max;
`ifdef STOPWATCH_LAP_EN
  logic       lap;
`endif

  int checks   = 0;
  int failures = 0;
  int n;

  string       tag_q[$];
  logic [29:0] exp_q[$];

  stopwatch_core #(
    .TICK_DIV (4),
    .CNT_W    (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef STOPWATCH_LAP_EN
    .lap        (lap),
`endif
    .seg0       (seg0),
    .seg1       (seg1),
    .seg2       (seg2),
    .seg3       (seg3),
    .running    (running),
    .at_max     (at_max)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3, input logic r,
                            input logic m);
    tag_q.push_back(tag);
    exp_q.push_back({e0, e1, e2, e3, r, m});
  endtask

  task automatic check_out();
    string       tag;
    logic [29:0] exp, obs;
    tag = tag_q.pop_front();
    exp = exp_q.pop_front();
    obs = {seg0, seg1, seg2, seg3, running, at_max};
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (seg0..3,running,at_max)", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap        = 1'b0;
`endif
    repeat (3) step();
    expect_out("reset", S0, S0, S0, S0, 1'b0, 1'b0);
    check_out();
    rst_n = 1'b1;
    expect_out("idle_20cyc", S0, S0, S0, S0, 1'b0, 1'b0);
    repeat (20) step();
    check_out();

    // Run from IDLE: ticks every 4 cycles, tenth tick 40 cycles after start.
    start_stop = 1'b1;
    expect_out("run_start", S0, S0, S0, S0, 1'b1, 1'b0);
    step();
    check_out();
    expect_out("seg_lag_00.09", S0, S0, S0, S9, 1'b1, 1'b0);
    repeat (40) step();
    check_out();
    expect_out("count_00.10", S0, S0, S1, S0, 1'b1, 1'b0);
    step();
    check_out();

    // Clear and start/stop edges together: clear wins.
    start_stop = 1'b0;
    step();
    start_stop = 1'b1;
    clear      = 1'b1;
    expect_out("clr_ss_same", S0, S0, S1, S0, 1'b0, 1'b0);
    step();
    check_out();
    expect_out("clr_zero", S0, S0, S0, S0, 1'b0, 1'b0);
    step();
    check_out();
    expect_out("clr_stays_idle", S0, S0, S0, S0, 1'b0, 1'b0);
    repeat (5) step();
    check_out();

    // Pause/resume: 6 RUN cycles leave prescaler at 2, so resume ticks 2 cycles later.
    start_stop = 1'b0;
    clear      = 1'b0;
    step();
    start_stop = 1'b1;
    expect_out("pr_start", S0, S0, S0, S0, 1'b1, 1'b0);
    step();
    check_out();
    start_stop = 1'b0;
    expect_out("pr_run6", S0, S0, S0, S1, 1'b1, 1'b0);
    repeat (6) step();
    check_out();
    start_stop = 1'b1;
    expect_out("pr_stop", S0, S0, S0, S1, 1'b0, 1'b0);
    step();
    check_out();
    start_stop = 1'b0;
    expect_out("pr_stop_hold", S0, S0, S0, S1, 1'b0, 1'b0);
    repeat (50) step();
    check_out();
    start_stop = 1'b1;
    expect_out("pr_resume", S0, S0, S0, S1, 1'b1, 1'b0);
    step();
    check_out();
    start_stop = 1'b0;
    expect_out("pr_resume_r2", S0, S0, S0, S1, 1'b1, 1'b0);
    repeat (2) step();
    check_out();
    expect_out("pr_resume_r3", S0, S0, S0, S2, 1'b1, 1'b0);
    step();
    check_out();

    // Run on to 99.99 plus one tick: 9998 further ticks, bounded wait.
    n = 0;
    while (!at_max && n < 45000) begin
      step();
      n++;
    end
    checks++;
    assert (n == 39991)
    else begin
      failures++;
      $error("FAIL max_cycles observed=%0d expected=%0d", n, 39991);
    end
    expect_out("max_reached", S9, S9, S9, S9, 1'b0, 1'b1);
    check_out();
    start_stop = 1'b1;
    expect_out("max_ss_ignored", S9, S9, S9, S9, 1'b0, 1'b1);
    step();
    check_out();
    start_stop = 1'b0;
    expect_out("max_hold", S9, S9, S9, S9, 1'b0, 1'b1);
    repeat (9) step();
    check_out();
    clear = 1'b1;
    expect_out("max_clear", S9, S9, S9, S9, 1'b0, 1'b0);
    step();
    check_out();
    expect_out("max_clear_seg", S0, S0, S0, S0, 1'b0, 1'b0);
    step();
    check_out();
    clear = 1'b0;

`ifdef STOPWATCH_LAP_EN
    step();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    repeat (20) step();
    lap = 1'b1;
    expect_out("lap_set", S0, S0, S0, S5, 1'b1, 1'b0);
    step();
    check_out();
    lap = 1'b0;
    expect_out("lap_frozen", S0, S0, S0, S5, 1'b1, 1'b0);
    repeat (32) step();
    check_out();
    lap = 1'b1;
    expect_out("lap_release_edge", S0, S0, S0, S5, 1'b1, 1'b0);
    step();
    check_out();
    lap = 1'b0;
    expect_out("lap_resume_00.13", S0, S0, S1, S3, 1'b1, 1'b0);
    step();
    check_out();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
